// File: rtl/dm_cache_ctrl_param.sv
// Parametrised direct-mapped, write-back, write-allocate cache controller.
// Sits between a CPU load/store port and a burst memory controller.
// Refill and write-back move one line as BEATS memory beats of MEM_W bits.
// A level-sensitive flush request writes back every dirty line and then
// pulses flush_done.
//
// Handshakes:
//   cpu side: the request is held (valid plus stable fields) until cpu_ready.
//     cpu_ready is a single-cycle completion pulse.
//   mem side: mem_valid stays high for the whole burst.
//     A beat completes on every cycle with mem_ready=1.
//     While mem_ready=0, address and data hold steady.
module dm_cache_ctrl_param #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 8,
  parameter int MEM_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [WORD_W-1:0] cpu_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic              mem_ready,
  input  logic [MEM_W-1:0]  mem_rdata
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = WORDS_PER_LINE * WORD_W;
  localparam int BEATS  = LINE_W / MEM_W;
  localparam int WPB    = MEM_W / WORD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    WRITE_BACK = 3'd2,
    ALLOCATE   = 3'd3,
    FLUSH      = 3'd4
  } state_t;

  // state is the observable FSM state for debug and checker binding
  state_t state, state_next;

  logic [LINE_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_bits;
  logic [LINES-1:0]  dirty_bits;
  logic [BEAT_W-1:0] beat;
  logic [IDX_W-1:0]  scan;
  logic              flushing;   // current write-back belongs to a flush

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [OFF_W-1:0]  cpu_off;
  logic [IDX_W-1:0]  line_idx;
  logic [LINE_W-1:0] cur_line;
  logic [TAG_W-1:0]  tag_sel;
  logic [OFF_W-1:0]  beat_off;
  logic [MEM_W-1:0]  beat_data;
  logic [WORD_W-1:0] cur_word;
  logic              hit;
  logic              scan_dirty;
  logic              scan_last;
  logic              last_beat;

  assign cpu_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx    = cpu_addr[OFF_W +: IDX_W];
  assign cpu_off    = cpu_addr[OFF_W-1:0];
  // A flush write-back works on the scanned line, everything else on the CPU line
  assign line_idx   = flushing ? scan : cpu_idx;
  assign cur_line   = data_mem[line_idx];
  assign hit        = valid_bits[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign scan_dirty = valid_bits[scan] && dirty_bits[scan];
  assign scan_last  = (scan == IDX_W'(LINES - 1));
  assign last_beat  = (beat == BEAT_W'(BEATS - 1));
  // Word offset of the current beat inside the line (beat * WPB)
  assign beat_off   = OFF_W'(int'(beat) * WPB);
  // Write-back targets the line's old tag, refill the requested tag
  assign tag_sel    = (state == WRITE_BACK) ? tag_mem[line_idx] : cpu_tag;

  // Select the MEM_W slice of the line addressed by the beat counter
  always_comb begin
    beat_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) beat_data = cur_line[b*MEM_W +: MEM_W];
    end
  end

  // Select the requested CPU word from the line
  always_comb begin
    cur_word = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (cpu_off == OFF_W'(w)) cur_word = cur_line[w*WORD_W +: WORD_W];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (flush_req)      state_next = FLUSH;
        else if (cpu_valid) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit)                                        state_next = IDLE;
        else if (valid_bits[cpu_idx] && dirty_bits[cpu_idx]) state_next = WRITE_BACK;
        else                                            state_next = ALLOCATE;
      end
      WRITE_BACK: begin
        if (mem_ready && last_beat) state_next = flushing ? FLUSH : ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ready && last_beat) state_next = COMPARE;
      end
      FLUSH: begin
        if (scan_dirty)     state_next = WRITE_BACK;
        else if (scan_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; everything idles at zero outside the states that drive it
  always_comb begin
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    flush_done = 1'b0;
    mem_valid  = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      COMPARE: begin
        cpu_ready = hit;
        if (hit && !cpu_rw) cpu_rdata = cur_word;
      end
      WRITE_BACK: begin
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {tag_sel, line_idx, beat_off};
        mem_wdata = beat_data;
      end
      ALLOCATE: begin
        mem_valid = 1'b1;
        mem_addr  = {tag_sel, line_idx, beat_off};
      end
      FLUSH: begin
        flush_done = !scan_dirty && scan_last;
      end
      default: ;
    endcase
  end

  // Line metadata, beat counter and flush scan pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
      beat       <= '0;
      scan       <= '0;
      flushing   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flushing <= flush_req;
          if (flush_req) scan <= '0;
        end
        COMPARE: begin
          if (hit && cpu_rw) dirty_bits[cpu_idx] <= 1'b1;
          if (!hit)          beat <= '0;
        end
        WRITE_BACK: begin
          if (mem_ready) begin
            if (last_beat) begin
              beat <= '0;
              if (flushing) dirty_bits[line_idx] <= 1'b0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            if (last_beat) begin
              beat                <= '0;
              valid_bits[cpu_idx] <= 1'b1;
              dirty_bits[cpu_idx] <= 1'b0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (scan_dirty) begin
            beat <= '0;
          end else if (scan_last) begin
            flushing <= 1'b0;
          end else begin
            scan <= scan + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage: CPU write hits and refill beats; contents are not reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == COMPARE && hit && cpu_rw) begin
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
          if (cpu_off == OFF_W'(w)) data_mem[cpu_idx][w*WORD_W +: WORD_W] <= cpu_wdata;
        end
      end
      if (state == ALLOCATE && mem_ready) begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat == BEAT_W'(b)) data_mem[cpu_idx][b*MEM_W +: MEM_W] <= mem_rdata;
        end
        if (last_beat) tag_mem[cpu_idx] <= cpu_tag;
      end
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl_param.sv
// Testbench for dm_cache_ctrl_param (default parameters: 8 lines, 4 words of
// 16 bits, 32-bit memory bus, 2 beats per line).
module tb_dm_cache_ctrl_param;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;
  localparam int MEM_W  = 32;
  localparam int BW     = 1 + ADDR_W + MEM_W;   // {rw, addr, wdata} beat record

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_valid, cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [WORD_W-1:0] cpu_rdata;
  logic              flush_req, flush_done;
  logic              mem_valid, mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic              mem_ready;
  logic [MEM_W-1:0]  mem_rdata;

  always #5 clk = ~clk;

  dm_cache_ctrl_param #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_LINE(4), .LINES(8), .MEM_W(MEM_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];      // expected memory beats, in order
  logic [BW-1:0] beat_tab[$];   // per-vector expected beats, drained into exp_q
  logic [WORD_W-1:0] mem_model [256];
  int   stall_cfg    = 0;
  int   stall_cnt    = 0;
  int   stall_cycles = 0;
  int   hold_err     = 0;
  int   beat_cnt     = 0;
  logic waiting      = 1'b0;
  logic [ADDR_W-1:0] held_addr = '0;
  logic held_rw = 1'b0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        hit;      // expect 2-cycle latency
    int          nbeats;   // expected memory beats for this access
  } vec_t;

  vec_t vecs[8];

  function automatic logic [BW-1:0] bt(input logic rw, input logic [15:0] a, input logic [31:0] d);
    return {rw, a, d};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_beat(input logic [BW-1:0] got);
    logic [BW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL beat_unexpected got=%h", got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL beat got=%h exp=%h", got, exp);
      end
    end
  endtask

  // ---------------- memory responder ----------------
  // Decides mem_ready on the falling edge; the beat completes on the next rising edge.
  initial begin
    logic [7:0] a;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (waiting && (mem_addr !== held_addr || mem_rw !== held_rw)) hold_err++;
        if (stall_cnt < stall_cfg) begin
          stall_cnt++;
          stall_cycles++;
          mem_ready = 1'b0;
          waiting   = 1'b1;
          held_addr = mem_addr;
          held_rw   = mem_rw;
        end else begin
          stall_cnt = 0;
          waiting   = 1'b0;
          mem_ready = 1'b1;
          a = mem_addr[7:0];
          mem_rdata = {mem_model[a + 8'd1], mem_model[a]};
          if (mem_rw) begin
            mem_model[a]        = mem_wdata[15:0];
            mem_model[a + 8'd1] = mem_wdata[31:16];
          end
          beat_cnt++;
          check_beat({mem_rw, mem_addr, mem_wdata});
        end
      end else begin
        mem_ready = 1'b0;
        stall_cnt = 0;
        waiting   = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_access(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
    rd  = '0;
    lat = -1;
    for (int c = 2; c <= 200; c++) begin
      @(negedge clk);
      if (cpu_ready) begin
        rd  = cpu_rdata;
        lat = c;
        break;
      end
    end
    cpu_valid = 1'b0;
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL cpu_timeout addr=%h", addr);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [15:0] rd;
    int lat;
    int b0;
    for (int k = 0; k < v.nbeats; k++) exp_q.push_back(beat_tab.pop_front());
    b0 = beat_cnt;
    cpu_access(v.rw, v.addr, v.wdata, rd, lat);
    if (v.chk_rd) check({name, "_rdata"}, 64'(rd), 64'(v.exp_rd));
    if (v.hit)    check({name, "_latency"}, 64'(lat), 64'd2);
    check({name, "_beats"}, 64'(beat_cnt - b0), 64'(v.nbeats));
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_flush(input string name, input int exp_beats);
    int  b0;
    int  dn;
    logic seen;
    b0 = beat_cnt;
    dn = 0;
    seen = 1'b0;
    @(negedge clk);
    flush_req = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (flush_done) begin
        dn++;
        seen = 1'b1;
        flush_req = 1'b0;
      end
    end
    flush_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (flush_done) dn++;
    end
    check({name, "_done_pulses"}, 64'(dn), 64'd1);
    check({name, "_beats"}, 64'(beat_cnt - b0), 64'(exp_beats));
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'hC300 | 16'(i);
    mem_model[4] = 16'h0000;
    mem_model[5] = 16'h1111;
    mem_model[6] = 16'h2222;
    mem_model[7] = 16'h3333;

    // rw, addr, wdata, chk_rd, exp_rd, hit, nbeats
    vecs[0] = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1111, 1'b0, 2};  // cold read miss
    vecs[1] = '{1'b0, 16'h0006, 16'h0000, 1'b1, 16'h2222, 1'b1, 0};  // read hit
    vecs[2] = '{1'b1, 16'h0005, 16'hABCD, 1'b0, 16'h0000, 1'b1, 0};  // write hit -> dirty
    vecs[3] = '{1'b0, 16'h0025, 16'h0000, 1'b1, 16'hC325, 1'b0, 4};  // dirty conflict miss
    vecs[4] = '{1'b1, 16'h0013, 16'h5555, 1'b0, 16'h0000, 1'b0, 2};  // write miss, allocate
    vecs[5] = '{1'b0, 16'h0012, 16'h0000, 1'b1, 16'hC312, 1'b1, 0};  // fetched word kept
    vecs[6] = '{1'b0, 16'h0013, 16'h0000, 1'b1, 16'h5555, 1'b1, 0};  // merged CPU word
    vecs[7] = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'hABCD, 1'b0, 2};  // written-back data returns

    beat_tab.push_back(bt(1'b0, 16'h0004, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0006, 32'h0));
    beat_tab.push_back(bt(1'b1, 16'h0004, 32'hABCD0000));
    beat_tab.push_back(bt(1'b1, 16'h0006, 32'h33332222));
    beat_tab.push_back(bt(1'b0, 16'h0024, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0026, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0010, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0012, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0004, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0006, 32'h0));

    rst = 1'b1; cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0; flush_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cpu_ready",  64'(cpu_ready),  64'd0);
    check("reset_cpu_rdata",  64'(cpu_rdata),  64'd0);
    check("reset_flush_done", 64'(flush_done), 64'd0);
    check("reset_mem_valid",  64'(mem_valid),  64'd0);
    check("reset_mem_rw",     64'(mem_rw),     64'd0);
    check("reset_mem_addr",   64'(mem_addr),   64'd0);
    check("reset_mem_wdata",  64'(mem_wdata),  64'd0);
    rst = 1'b0;

    // Table-driven CPU accesses
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Flush: dirty lines at index 1 and 6 only
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    beat_tab.push_back(bt(1'b0, 16'h0004, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0006, 32'h0));
    run_vec("fl_w1", '{1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000, 1'b0, 2});
    beat_tab.push_back(bt(1'b0, 16'h0018, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h001A, 32'h0));
    run_vec("fl_w6", '{1'b1, 16'h001A, 16'h7777, 1'b0, 16'h0000, 1'b0, 2});
    exp_q.push_back(bt(1'b1, 16'h0004, 32'h12340000));
    exp_q.push_back(bt(1'b1, 16'h0006, 32'h33332222));
    exp_q.push_back(bt(1'b1, 16'h0018, 32'hC319C318));
    exp_q.push_back(bt(1'b1, 16'h001A, 32'hC31B7777));
    do_flush("flush1", 4);
    run_vec("fl_hit1", '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234, 1'b1, 0});
    run_vec("fl_hit6", '{1'b0, 16'h001A, 16'h0000, 1'b1, 16'h7777, 1'b1, 0});
    do_flush("flush2", 0);   // dirty bits were cleared: nothing to write back

    // Refill with mem_ready low for 3 cycles before each beat
    stall_cfg = 3; stall_cycles = 0; hold_err = 0;
    beat_tab.push_back(bt(1'b0, 16'h0030, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0032, 32'h0));
    run_vec("stall_rd", '{1'b0, 16'h0031, 16'h0000, 1'b1, 16'hC331, 1'b0, 2});
    check("stall_cycles", 64'(stall_cycles), 64'd6);
    check("stall_hold",   64'(hold_err),     64'd0);
    stall_cfg = 0;
    run_vec("stall_hit", '{1'b0, 16'h0033, 16'h0000, 1'b1, 16'hC333, 1'b1, 0});

    // Reset in the middle of a refill, after beat 0
    stall_cfg = 2;
    exp_q.push_back(bt(1'b0, 16'h0040, 32'h0));
    b0 = beat_cnt;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0041; cpu_wdata = '0;
    for (int i = 0; i < 100 && beat_cnt == b0; i++) @(negedge clk);
    check("rstmid_beat0", 64'(beat_cnt - b0), 64'd1);
    @(negedge clk);
    rst = 1'b1; cpu_valid = 1'b0;
    @(negedge clk);
    check("rstmid_mem_valid", 64'(mem_valid), 64'd0);
    check("rstmid_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rstmid_mem_addr",  64'(mem_addr),  64'd0);
    check("rstmid_sb_empty",  64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    stall_cfg = 0;
    beat_tab.push_back(bt(1'b0, 16'h0040, 32'h0));
    beat_tab.push_back(bt(1'b0, 16'h0042, 32'h0));
    run_vec("rstmid_refill", '{1'b0, 16'h0041, 16'h0000, 1'b1, 16'hC341, 1'b0, 2});

    repeat (3) @(negedge clk);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl_param.md
Name: dm_cache_ctrl_param

Overview:
Parametrised direct-mapped, write-back, write-allocate cache controller. It is the successor to the fixed 8-line, 4x16-bit-word controller. Line size, line count, word width and memory bus width are generic, and refill/write-back use multi-beat bursts counted by a beat counter. Tag/valid/dirty and data arrays are internal. Adds a whole-cache flush (write back all dirty lines) with a completion pulse. Sits between the CPU load/store port and the memory controller.

Parameters:
ADDR_W, 16, CPU word-address width
WORD_W, 16, CPU data word width
WORDS_PER_LINE, 4, words per line (power of 2, >=2); OFF_W=log2
LINES, 8, number of lines (power of 2); IDX_W=log2; TAG_W=ADDR_W-IDX_W-OFF_W
MEM_W, 32, memory bus width (multiple of WORD_W, divides line width); BEATS=WORDS_PER_LINE*WORD_W/MEM_W, WPB=MEM_W/WORD_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpu_valid  in  1  CPU request; held with fields stable until cpu_ready
cpu_rw  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address {tag,index,offset}
cpu_wdata  in  WORD_W  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  WORD_W  read data, valid when cpu_ready && !cpu_rw
flush_req  in  1  flush request, level; sampled in IDLE only
flush_done  out  1  one-cycle pulse when flush complete
mem_valid  out  1  memory beat request
mem_rw  out  1  1=write-back beat, 0=refill beat
mem_addr  out  ADDR_W  word address of beat
mem_wdata  out  MEM_W  write-back beat data
mem_ready  in  1  beat accepted/returned this cycle
mem_rdata  in  MEM_W  refill beat data, valid with mem_ready

Behaviour:
- Reset: state IDLE; all valid and dirty bits 0; beat counter 0. cpu_ready, flush_done and mem_valid are 0. mem_rw, mem_addr, mem_wdata and cpu_rdata are 0. Data array not reset. Reset mid-burst abandons the burst immediately and does not wait for mem_ready.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH.
- IDLE: flush_req=1 -> FLUSH with scan index 0 (flush has priority over cpu_valid). Otherwise cpu_valid=1 -> COMPARE.
- COMPARE: hit = valid[idx] && tag[idx]==addr tag.
  - Read hit: cpu_ready=1, cpu_rdata=word[offset] -> IDLE.
  - Write hit: word[offset]<=cpu_wdata, dirty<=1, cpu_ready=1 -> IDLE.
  - Hit latency is 2 cycles from the cpu_valid rise seen in IDLE.
  - Miss, line invalid or clean -> ALLOCATE.
  - Miss, line valid and dirty -> WRITE_BACK.
  - The beat counter is cleared on either miss transition.
- Burst protocol, both directions:
  - mem_valid=1 continuously in WRITE_BACK/ALLOCATE.
  - Beat b address = line base + b*WPB.
  - WRITE_BACK base = {old tag, idx, 0}; ALLOCATE base = {cpu tag, idx, 0}.
  - Each cycle with mem_ready=1 completes beat b and increments the counter.
  - mem_wdata = line bits [(b+1)*MEM_W-1 : b*MEM_W].
  - Refill writes mem_rdata into the same slice.
  - mem_ready=0 stalls; address and data are held stable.
- WRITE_BACK: after beat BEATS-1 completes, clear the counter -> ALLOCATE. In flush context, instead clear dirty -> FLUSH.
- ALLOCATE: after the last beat, set tag, valid=1, dirty=0 -> COMPARE. The retry is a hit, so a write miss merges the CPU word over the fetched line.
- FLUSH: examine line at scan index.
  - If valid && dirty -> WRITE_BACK for that line.
  - Else advance the index.
  - After index LINES-1 is handled: flush_done=1 for one cycle -> IDLE.
  - Valid bits are preserved.
  - cpu_valid during a flush is ignored until return to IDLE.
- cpu_ready is never asserted outside COMPARE. mem_valid is never asserted outside WRITE_BACK/ALLOCATE.

Test Plan:
- Cold read 0x0005, mem returns 0x11110000/0x33332222 on beats 0/1 -> mem_addr 0x0004 then 0x0006, mem_rw=0. Then cpu_ready with cpu_rdata=0x1111; line 1 valid, clean.
- Read hit 0x0006 after the above -> cpu_ready exactly 2 cycles after cpu_valid, rdata 0x2222, no mem_valid.
- Write 0x0005 data 0xABCD (hit), then read 0x0025 (same index, tag 1) -> write-back beats at 0x0004 (wdata 0xABCD0000) and 0x0006 (wdata 0x33332222). Then refill at 0x0024/0x0026, then cpu_ready.
- mem_ready held low 3 cycles per beat during refill -> mem_addr/mem_valid stable, final data correct, exactly BEATS beats.
- Dirty lines at idx 1 and 6, flush_req -> write-back bursts for idx 1 then 6 only. flush_done pulses once; dirty bits cleared, valid bits kept; the next read of those lines hits.
- rst asserted mid-ALLOCATE (after beat 0) -> next cycle IDLE, mem_valid=0. A read of the same address then misses and performs a full 2-beat refill.
